uart_rx_fsm: RTL and testbench

- UART receive path: oversampled serial input, start/stop framing, optional parity check, parallel word output.
- Receive-side counterpart of the team's UART transmitter. Frame format is identical: start(0), DATA_WIDTH bits LSB first, optional parity, one stop(1).
- Sits between the pad-side rx_in line and the host/consumer logic.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_fsm.sv | 139 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its consumer.
// The master side drives the serial line and frame options. The slave side is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;
  logic                  busy;
  logic [2:0]            state_dbg;

  // data_valid, par_err and stop_err are single-cycle pulses with no back-pressure.
  // The consumer must capture data_out in the cycle that data_valid is high.
  modport master (
    output rx_in, par_en, par_typ,
    input  data_out, data_valid, par_err, stop_err, busy, state_dbg
  );

  modport slave (
    input  rx_in, par_en, par_typ,
    output data_out, data_valid, par_err, stop_err, busy, state_dbg
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// Oversampled UART receiver: start/stop framing, optional parity, parallel word out.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority bit sampling around the bit centre.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_EDGE = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  par_en_q, par_typ_q, par_mis;
  logic                  bit_val, at_sample, at_end, last_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] VOTE0_EDGE  = CW'(PRESCALE/2 - 2);
  localparam logic [CW-1:0] VOTE1_EDGE  = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] DECIDE_EDGE = CW'(PRESCALE/2);
  logic vote0, vote1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
    end else begin
      if (edge_cnt == VOTE0_EDGE) vote0 <= rx_s;
      if (edge_cnt == VOTE1_EDGE) vote1 <= rx_s;
    end
  end

  // The third vote is the live rx_s at the decision edge.
  assign bit_val = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);
`else
  localparam logic [CW-1:0] DECIDE_EDGE = CW'(PRESCALE/2 - 1);
  assign bit_val = rx_s;
`endif

  assign at_sample = (edge_cnt == DECIDE_EDGE);
  assign at_end    = (edge_cnt == LAST_EDGE);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign shift_nxt = (shift_reg >> 1) | (DATA_WIDTH'(bit_val) << (DATA_WIDTH - 1));
  assign bus.state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (at_sample && bit_val) state_nxt = S_IDLE;
        else if (at_end)          state_nxt = S_DATA;
      end
      S_DATA:   if (at_end && last_bit) state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_nxt = S_STOP;
      // Leaving at mid-stop-bit gives half a bit of slack to catch a following start edge.
      S_STOP:   if (at_sample) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      par_mis        <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stop_err   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      rx_meta        <= bus.rx_in;
      rx_s           <= rx_meta;
      state          <= state_nxt;
      bus.busy       <= (state != S_IDLE);
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stop_err   <= 1'b0;

      if (state == S_IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        par_mis  <= 1'b0;
        if (!rx_s) begin
          par_en_q  <= bus.par_en;
          par_typ_q <= bus.par_typ;
        end
      end else begin
        edge_cnt <= at_end ? '0 : edge_cnt + 1'b1;
      end

      case (state)
        S_DATA: begin
          if (at_sample) shift_reg <= shift_nxt;
          if (at_end)    bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
        end
        S_PARITY: begin
          if (at_sample) par_mis <= (bit_val != ((^shift_reg) ^ par_typ_q));
        end
        S_STOP: begin
          if (at_sample) begin
            bus.stop_err <= ~bit_val;
            bus.par_err  <= par_mis;
            if (bit_val && !par_mis) begin
              bus.data_valid <= 1'b1;
              bus.data_out   <= shift_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed testbench for uart_rx_fsm with PRESCALE=8 and DATA_WIDTH=8.
// Pulses are counted by a negedge monitor, and received words go to a queue.
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int PS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();
  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_cnt  = 0;
  int pe_cnt  = 0;
  int se_cnt  = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int dv_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid) begin
        dv_cnt++;
        got_q.push_back(bus.data_out);
        dv_cyc_q.push_back(cyc);
      end
      if (bus.par_err)  pe_cnt++;
      if (bus.stop_err) se_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    repeat (PS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic with_par, input logic par_bit,
                            input logic stop_bit);
    logic [DW-1:0] dd;
    dd = d;
    bus.par_en = with_par;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(dd[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_in = 1'b1;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    n_tests++;
    if ({bus.data_valid, bus.par_err, bus.stop_err, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.data_valid, bus.par_err, bus.stop_err, bus.busy});
    end
    n_tests++;
    if (bus.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
    rst = 1'b0;
    idle(16);
  endtask

  task automatic test_basic();
    int dv0, pe0, se0;
    logic [DW-1:0] g, e;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    got_q.delete();
    exp_q.push_back(8'hA5);
    bus.par_en = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b expected 1", bus.busy); end
    for (int i = 1; i < DW; i++) send_bit(((8'hA5 >> i) & 8'h01) != 8'h00);
    send_bit(1'b1);
    idle(4);
    n_tests++;
    if (dv_cnt - dv0 != 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", dv_cnt - dv0); end
    n_tests++;
    if (pe_cnt != pe0 || se_cnt != se0) begin
      n_fail++;
      $display("FAIL basic_err: got par %0d stop %0d expected 0 0", pe_cnt - pe0, se_cnt - se0);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (got_q.size() == 0) begin n_fail++; $display("FAIL basic_word: got none expected %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL basic_word: got %h expected %h", g, e); end
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_parity();
    int dv0, pe0;
    dv0 = dv_cnt; pe0 = pe_cnt;
    bus.par_typ = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    if (dv_cnt - dv0 != 1 || bus.data_out !== 8'h3C) begin
      n_fail++; $display("FAIL par_even_ok: got valid %0d data %h expected 1 3c", dv_cnt - dv0, bus.data_out);
    end
    n_tests++;
    if (pe_cnt != pe0) begin n_fail++; $display("FAIL par_even_ok_err: got %0d expected 0", pe_cnt - pe0); end
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(4);
    n_tests++;
    if (pe_cnt - pe0 != 1) begin n_fail++; $display("FAIL par_even_bad: got par_err %0d expected 1", pe_cnt - pe0); end
    n_tests++;
    if (dv_cnt != dv0 || bus.data_out !== 8'h3C) begin
      n_fail++; $display("FAIL par_even_bad_hold: got valid %0d data %h expected 0 3c", dv_cnt - dv0, bus.data_out);
    end
    dv0 = dv_cnt; pe0 = pe_cnt;
    bus.par_typ = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    if (dv_cnt - dv0 != 1 || pe_cnt != pe0 || bus.data_out !== 8'h07) begin
      n_fail++;
      $display("FAIL par_odd_ok: got valid %0d perr %0d data %h expected 1 0 07", dv_cnt - dv0, pe_cnt - pe0, bus.data_out);
    end
    bus.par_typ = 1'b0;
    bus.par_en = 1'b0;
  endtask

  task automatic test_glitch();
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    bus.rx_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", bus.busy); end
    repeat (8) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop: got %b expected 0", bus.busy); end
    n_tests++;
    if (dv_cnt != dv0 || pe_cnt != pe0 || se_cnt != se0) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d %0d %0d expected 0 0 0", dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
    end
    idle(8);
  endtask

  task automatic test_stop_err();
    int dv0, se0;
    dv0 = dv_cnt; se0 = se_cnt;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    idle(8);
    n_tests++;
    if (se_cnt - se0 != 1) begin n_fail++; $display("FAIL stop_err_pulse: got %0d expected 1", se_cnt - se0); end
    n_tests++;
    if (dv_cnt != dv0 || bus.data_out !== 8'h07) begin
      n_fail++; $display("FAIL stop_err_hold: got valid %0d data %h expected 0 07", dv_cnt - dv0, bus.data_out);
    end
    dv0 = dv_cnt; se0 = se_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    if (dv_cnt - dv0 != 1 || se_cnt != se0 || bus.data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL stop_recover: got valid %0d serr %0d data %h expected 1 0 55", dv_cnt - dv0, se_cnt - se0, bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] g, e;
    int c0, c1;
    got_q.delete();
    dv_cyc_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        n_tests++;
        if (g !== e) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, g, e); end
      end
      c0 = dv_cyc_q.pop_front();
      c1 = dv_cyc_q.pop_front();
      n_tests++;
      if (c1 - c0 != 10 * PS) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", c1 - c0, 10 * PS); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int dv0, pe0, se0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus.busy); end
    rst = 1'b1;
    bus.rx_in = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got data %h busy %b state %0d expected 00 0 0", bus.data_out, bus.busy, bus.state_dbg);
    end
    n_tests++;
    if ({bus.data_valid, bus.par_err, bus.stop_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_pulses: got %b expected 000", {bus.data_valid, bus.par_err, bus.stop_err});
    end
    rst = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    idle(16);
    n_tests++;
    if (dv_cnt != dv0 || pe_cnt != pe0 || se_cnt != se0) begin
      n_fail++; $display("FAIL rst_mid_no_pulse: got %0d %0d %0d expected 0 0 0", dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
    end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    if (dv_cnt - dv0 != 1 || bus.data_out !== 8'h81) begin
      n_fail++; $display("FAIL rst_mid_next: got valid %0d data %h expected 1 81", dv_cnt - dv0, bus.data_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
